// File: rtl/muldiv_unit_pkg.sv
// Shared RV32M funct3 encodings and FSM state encoding for the multiply/divide unit.
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // rs1 is sign-interpreted by MULH, MULHSU, DIV and REM
  function automatic logic rs1_signed(input logic [2:0] f);
    return (f == F3_MULH) || (f == F3_MULHSU) || (f == F3_DIV) || (f == F3_REM);
  endfunction

  function automatic logic rs2_signed(input logic [2:0] f);
    return (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M mul/div: radix-2 step per cycle on operand magnitudes, sign fixed at the end.
// Latency 33 cycles (1 cycle for divide-by-zero / signed overflow); BUSY high meanwhile.
// No backpressure: START is ignored while BUSY, KILL aborts with no VALID.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic            KILL,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic [2:0]      SELECT,
  output logic            BUSY,
  output logic            VALID,
  output logic [XLEN-1:0] RESULT
);

  state_t              state, state_nxt;
  logic [2*XLEN-1:0]   acc;
  logic [XLEN-1:0]     opnd;
  logic [4:0]          cnt;
  logic [2:0]          sel_q;
  logic                neg_q;

  logic                sign_a, sign_b;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic                div_zero, div_ovf, fast, accept;
  logic [XLEN:0]       mul_sum, div_diff;
  logic [2*XLEN-1:0]   mul_nxt, div_nxt, prod_s;
  logic [XLEN-1:0]     quo_s, rem_s, res_fin;

  assign sign_a   = DATA1[XLEN-1] & rs1_signed(SELECT);
  assign sign_b   = DATA2[XLEN-1] & rs2_signed(SELECT);
  assign mag_a    = sign_a ? -DATA1 : DATA1;
  assign mag_b    = sign_b ? -DATA2 : DATA2;
  assign div_zero = SELECT[2] && (DATA2 == '0);
  assign div_ovf  = SELECT[2] && !SELECT[0] && (DATA1 == {1'b1, {(XLEN-1){1'b0}}})
                    && (DATA2 == '1);
  assign fast     = div_zero || div_ovf;
  assign accept   = (state == ST_IDLE) && START && !KILL;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step
  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_nxt = {mul_sum, acc[XLEN-1:1]};

  // Restoring divide: acc = {partial remainder, dividend bits becoming quotient bits}
  assign div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
  assign div_nxt  = div_diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (KILL) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (START) state_nxt = fast ? ST_DONE : ST_CALC;
        ST_CALC: if (cnt == 5'(XLEN-1)) state_nxt = ST_DONE;
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    BUSY = (state != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      acc   <= '0;
      opnd  <= '0;
      cnt   <= '0;
      sel_q <= F3_MUL;
      neg_q <= 1'b0;
    end else if (accept) begin
      sel_q <= SELECT;
      cnt   <= '0;
      if (fast) begin
        // Preload the final {remainder, quotient}; no sign correction applies
        acc   <= div_zero ? {DATA1, {XLEN{1'b1}}} : {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
        opnd  <= '0;
        neg_q <= 1'b0;
      end else begin
        acc   <= {{XLEN{1'b0}}, SELECT[2] ? mag_a : mag_b};
        opnd  <= SELECT[2] ? mag_b : mag_a;
        neg_q <= (SELECT == F3_REM) ? sign_a : (sign_a ^ sign_b);
      end
    end else if (state == ST_CALC) begin
      acc <= sel_q[2] ? div_nxt : mul_nxt;
      cnt <= cnt + 5'd1;
    end
  end

  assign prod_s = neg_q ? -acc : acc;
  assign quo_s  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem_s  = neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_comb begin
    case (sel_q)
      F3_MUL:                        res_fin = prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  res_fin = prod_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               res_fin = quo_s;
      default:                       res_fin = rem_s;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      VALID  <= 1'b0;
      RESULT <= '0;
    end else if ((state == ST_DONE) && !KILL) begin
      VALID  <= 1'b1;
      RESULT <= res_fin;
    end else begin
      VALID  <= 1'b0;
    end
  end

endmodule
